array_loader: RTL and testbench

ARRAY_LOADER -- requirements
Module: array_loader

---
 rtl/array_pkg.sv | 15 +
 rtl/array_address.sv | 16 +
 rtl/array_loader.sv | 146 ++++++++++++++
 tb/tb_array_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared constants and FSM state type for the array loader/reader family.
package array_pkg;

    localparam int MemoryElementWidth = 12;
    localparam int NArea              = 3;
    localparam int NArrays            = 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        FINISH
    } state_t;

endpackage

// File: rtl/array_address.sv
// Maps (array index, element index) to a flat heap address: array*NArea+index.
// The arithmetic is done at width W; callers keep array < NArrays so it never wraps.
module array_address #(
    parameter int W     = 12,
    parameter int NArea = 3
) (
    input  logic [W-1:0] i_array,
    input  logic [W-1:0] i_index,
    output logic [W-1:0] o_addr
);

    localparam logic [W-1:0] NAreaW = W'(NArea);

    assign o_addr = i_array * NAreaW + i_index;

endmodule

// File: rtl/array_loader.sv
// Streams elements into one heap area and keeps its arraySizes entry current.
// A load clears the size entry, writes each accepted element together with the
// running size, and ends on in_last or when the area is full.
module array_loader #(
    parameter int MemoryElementWidth = array_pkg::MemoryElementWidth,
    parameter int NArea              = array_pkg::NArea,
    parameter int NArrays            = array_pkg::NArrays
) (
    input  logic                          i_clock,
    input  logic                          i_reset,      // active-low, asynchronous
    input  logic                          i_start,
    input  logic [MemoryElementWidth-1:0] i_array,
    input  logic                          i_in_valid,
    input  logic [MemoryElementWidth-1:0] i_in_data,
    input  logic                          i_in_last,
    output logic                          o_in_ready,
    output logic                          o_heap_we,
    output logic [MemoryElementWidth-1:0] o_heap_addr,
    output logic [MemoryElementWidth-1:0] o_heap_wdata,
    output logic                          o_size_we,
    output logic [MemoryElementWidth-1:0] o_size_addr,
    output logic [MemoryElementWidth-1:0] o_size_wdata,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overflow,
    output logic                          o_error,
    output logic [MemoryElementWidth-1:0] o_count
);

    import array_pkg::*;

    localparam int            W        = MemoryElementWidth;
    localparam logic [W-1:0]  NAreaW   = W'(NArea);
    localparam logic [W-1:0]  NArraysW = W'(NArrays);
    localparam logic [W-1:0]  OneW     = W'(1);

    state_t       r_state;
    state_t       w_next_state;
    logic [W-1:0] r_array;
    logic [W-1:0] r_count;
    logic         r_overflow;
    logic         r_error;

    logic         w_in_ready;
    logic         w_transfer;
    logic [W-1:0] w_count_next;
    logic         w_area_full;
    logic [W-1:0] w_heap_addr;

    assign w_in_ready   = (r_state == LOAD) && (r_count < NAreaW);
    assign w_transfer   = w_in_ready && i_in_valid;
    assign w_count_next = r_count + OneW;
    assign w_area_full  = (w_count_next == NAreaW);

    array_address #(
        .W     (W),
        .NArea (NArea)
    ) u_array_address (
        .i_array (r_array),
        .i_index (r_count),
        .o_addr  (w_heap_addr)
    );

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // (which would infer a latch).
        w_next_state = r_state;
        unique case (r_state)
            IDLE:   if (i_start) w_next_state = CLEAR;
            CLEAR:  w_next_state = r_error ? FINISH : LOAD;
            LOAD:   if (w_transfer && (i_in_last || w_area_full)) w_next_state = FINISH;
            FINISH: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Load context: target array, element count and end-of-load status flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_array    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_array    <= i_array;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_error    <= (i_array >= NArraysW);
        end else if (w_transfer) begin
            r_count <= w_count_next;
            if (w_area_full && !i_in_last) r_overflow <= 1'b1;
        end
    end

    // Output decode: writes, handshake and completion flags.
    always_comb begin
        o_in_ready   = w_in_ready;
        o_heap_we    = 1'b0;
        o_heap_addr  = '0;
        o_heap_wdata = '0;
        o_size_we    = 1'b0;
        o_size_addr  = '0;
        o_size_wdata = '0;
        o_done       = 1'b0;
        o_overflow   = 1'b0;
        o_error      = 1'b0;
        unique case (r_state)
            IDLE: ;
            CLEAR: begin
                if (!r_error) begin
                    o_size_we   = 1'b1;
                    o_size_addr = r_array;
                end
            end
            LOAD: begin
                if (w_transfer) begin
                    o_heap_we    = 1'b1;
                    o_heap_addr  = w_heap_addr;
                    o_heap_wdata = i_in_data;
                    o_size_we    = 1'b1;
                    o_size_addr  = r_array;
                    o_size_wdata = w_count_next;
                end
            end
            FINISH: begin
                o_done     = 1'b1;
                o_overflow = r_overflow;
                o_error    = r_error;
            end
            default: ;
        endcase
    end

    assign o_busy  = (r_state != IDLE);
    assign o_count = r_count;

endmodule

// File: tb/tb_array_loader.sv
// Scoreboard bench for array_loader: a driver issues loads and pushes the
// expected write/done sequence; a monitor pops and compares on every DUT event.
module tb_array_loader;

    localparam int W       = 12;
    localparam int NAREA   = 3;
    localparam int NARRAYS = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [W-1:0]  i_array;
    logic          i_in_valid;
    logic [W-1:0]  i_in_data;
    logic          i_in_last;
    logic          o_in_ready, o_heap_we, o_size_we, o_busy, o_done, o_overflow, o_error;
    logic [W-1:0]  o_heap_addr, o_heap_wdata, o_size_addr, o_size_wdata, o_count;

    array_loader #(
        .MemoryElementWidth (W),
        .NArea              (NAREA),
        .NArrays            (NARRAYS)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_start      (i_start),
        .i_array      (i_array),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .i_in_last    (i_in_last),
        .o_in_ready   (o_in_ready),
        .o_heap_we    (o_heap_we),
        .o_heap_addr  (o_heap_addr),
        .o_heap_wdata (o_heap_wdata),
        .o_size_we    (o_size_we),
        .o_size_addr  (o_size_addr),
        .o_size_wdata (o_size_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_error      (o_error),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    typedef enum int { EV_HEAP, EV_SIZE, EV_DONE } ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       addr;
        int       data;
        int       ov;
        int       er;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input int a, input int d, input int ov, input int er);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d; e.ov = ov; e.er = er;
        exp_q.push_back(e);
    endtask

    // Reference model: expected event sequence for one load, from the
    // behavioural rules (clear, element-by-element fill, stop on last or full).
    task automatic model(input int arr, input int n, input int d[8], input int last_at,
                         output int acc);
        acc = 0;
        if (arr >= NARRAYS) begin
            push(EV_DONE, 0, 0, 0, 1);
            return;
        end
        push(EV_SIZE, arr, 0, 0, 0);
        for (int i = 0; i < n && acc < NAREA; i++) begin
            push(EV_HEAP, arr * NAREA + acc, d[i], 0, 0);
            push(EV_SIZE, arr, acc + 1, 0, 0);
            acc++;
            if (i == last_at) break;
        end
        push(EV_DONE, 0, 0, (last_at >= 0 && last_at < acc) ? 0 : 1, 0);
    endtask

    task automatic pop_cmp(input ev_kind_t k, input int a, input int d, input int ov, input int er);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0d, expected none (t=%0t)",
                     k, a, d, $time);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        if (k == e.kind) begin
            case (k)
                EV_HEAP: begin check("heap_addr", a, e.addr); check("heap_wdata", d, e.data); end
                EV_SIZE: begin check("size_addr", a, e.addr); check("size_wdata", d, e.data); end
                default: begin check("done_overflow", ov, e.ov); check("done_error", er, e.er); end
            endcase
        end
    endtask

    // Monitor: compare every write and completion pulse against the scoreboard.
    always @(negedge clk) begin
        if (o_heap_we) pop_cmp(EV_HEAP, int'(o_heap_addr), int'(o_heap_wdata), 0, 0);
        if (o_size_we) pop_cmp(EV_SIZE, int'(o_size_addr), int'(o_size_wdata), 0, 0);
        if (o_done) begin
            pop_cmp(EV_DONE, 0, 0, int'(o_overflow), int'(o_error));
            done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, int'(o_in_ready), 0);
        check({tag, "_heap_we"},  int'(o_heap_we), 0);
        check({tag, "_size_we"},  int'(o_size_we), 0);
        check({tag, "_busy"},     int'(o_busy), 0);
        check({tag, "_done"},     int'(o_done), 0);
        check({tag, "_overflow"}, int'(o_overflow), 0);
        check({tag, "_error"},    int'(o_error), 0);
        check({tag, "_count"},    int'(o_count), 0);
        check({tag, "_addrs"},    int'(o_heap_addr | o_size_addr), 0);
        check({tag, "_wdatas"},   int'(o_heap_wdata | o_size_wdata), 0);
    endtask

    // Present one element and hold it until the loader accepts it.
    task automatic feed(input int data, input logic last);
        bit ok = 0;
        i_in_valid = 1'b1;
        i_in_data  = W'(data);
        i_in_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = o_in_ready;
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: element %0d never accepted, expected accept", data);
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic run_load(input string name, input int arr, input int n, input int d[8],
                            input int gap[8], input int last_at, input bit start_noise);
        int acc;
        int prev = done_seen;
        model(arr, n, d, last_at, acc);
        i_array = W'(arr);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_array = W'($urandom_range(0, 7));
        if (arr >= NARRAYS) begin
            @(negedge clk);
            check({name, "_err_cycle1_done"}, int'(o_done), 0);
            tick();
            @(negedge clk);
            check({name, "_err_cycle2_done"}, int'(o_done), 1);
            check({name, "_err_cycle2_error"}, int'(o_error), 1);
        end else begin
            for (int i = 0; i < acc; i++) begin
                repeat (gap[i]) begin
                    i_in_valid = 1'b0;
                    i_start    = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    i_array    = W'($urandom_range(0, 7));
                    tick();
                end
                i_start = 1'b0;
                feed(d[i], logic'(i == last_at));
            end
            // Elements beyond a full area must be refused.
            if (!(last_at >= 0 && last_at < acc)) begin
                for (int i = acc; i < n; i++) begin
                    i_in_valid = 1'b1;
                    i_in_data  = W'(d[i]);
                    @(negedge clk);
                    check({name, "_ready_when_full"}, int'(o_in_ready), 0);
                    tick();
                end
                i_in_valid = 1'b0;
            end
        end
        for (int k = 0; k < 20 && done_seen == prev; k++) @(posedge clk);
        check({name, "_done_seen"}, done_seen - prev, 1);
        #1;
        check({name, "_count"}, int'(o_count), acc);
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        check({name, "_busy_after"}, int'(o_busy), 0);
        check({name, "_count_hold"}, int'(o_count), acc);
    endtask

    initial begin
        int d[8];
        int g[8];
        int acc;

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_array    = '0;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_in_last  = 1'b0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        d = '{10, 20, 30, 0, 0, 0, 0, 0};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_load("three", 0, 3, d, g, 2, 1'b0);

        d = '{7, 0, 0, 0, 0, 0, 0, 0};
        run_load("single", 0, 1, d, g, 0, 1'b0);

        d = '{10, 20, 30, 0, 0, 0, 0, 0};
        g = '{0, 2, 1, 0, 0, 0, 0, 0};
        run_load("gapped", 0, 3, d, g, 2, 1'b1);

        d = '{5, 6, 7, 8, 0, 0, 0, 0};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_load("overflow", 0, 4, d, g, -1, 1'b0);

        run_load("bad_array", 1, 0, d, g, -1, 1'b0);

        // Abort a load with reset after the second transfer.
        d = '{41, 42, 43, 0, 0, 0, 0, 0};
        model(0, 2, d, -1, acc);
        void'(exp_q.pop_back());
        i_array = '0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        feed(41, 1'b0);
        feed(42, 1'b0);
        i_in_valid = 1'b1;
        i_in_data  = W'(43);
        i_in_last  = 1'b1;
        rst_n      = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) tick();
        check("abort_pending", exp_q.size(), 0);
        exp_q.delete();
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        rst_n      = 1'b1;
        tick();
        d = '{10, 20, 30, 0, 0, 0, 0, 0};
        run_load("after_abort", 0, 3, d, g, 2, 1'b0);

        // Randomized loads: lengths, gaps, last position and target array.
        for (int t = 0; t < 40; t++) begin
            int n       = $urandom_range(1, 5);
            int last_at = int'($urandom_range(0, n)) - 1;
            int arr     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (last_at < 0 && n < NAREA) last_at = n - 1;
            for (int i = 0; i < 8; i++) begin
                d[i] = int'($urandom_range(0, (1 << W) - 1));
                g[i] = int'($urandom_range(0, 2));
            end
            run_load("random", arr, n, d, g, last_at, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
